// File: rtl/ultrasonic_echo_responder_if.sv
// Trigger/echo bundle between a ranging controller (master) and the
// emulated ultrasonic sensor (slave).
interface ultrasonic_echo_responder_if;
    logic        trig;
    logic [15:0] distance_us;
    logic        echo;
    logic        busy;
    logic        trig_short;
    logic        clamped;

    modport master (
        output trig, distance_us,
        input  echo, busy, trig_short, clamped
    );

    modport slave (
        input  trig, distance_us,
        output echo, busy, trig_short, clamped
    );
endinterface

// File: rtl/ultrasonic_echo_responder.sv
// HC-SR04-style sensor emulator: accepts a trigger pulse and answers with an echo
// whose width is the programmed distance in us. Optional macro ECHO_JITTER_EN adds 0-7 us LFSR jitter.
module ultrasonic_echo_responder #(
    parameter int CLK_HZ      = 40000000,
    parameter int MIN_TRIG_US = 10,
    parameter int BURST_US    = 200,
    parameter int MAX_ECHO_US = 38000,
    parameter int HOLDOFF_US  = 10000
) (
    input  logic                           clk,
    input  logic                           nreset,
    ultrasonic_echo_responder_if.slave     bus
);

    localparam int          DIV     = CLK_HZ / 1000000;
    localparam int          PW      = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [15:0] MIN_T   = 16'(MIN_TRIG_US);
    localparam logic [15:0] BURST_T = 16'(BURST_US);
    localparam logic [15:0] MAX_T   = 16'(MAX_ECHO_US);
    localparam logic [15:0] HOLD_T  = 16'(HOLDOFF_US);

    typedef enum logic [2:0] {
        S_IDLE,
        S_TRIG_HI,
        S_BURST,
        S_ECHO,
        S_HOLDOFF
    } state_t;

    state_t      state, state_nx;
    logic        trig_s1, trig_s2, trig_d;
    logic        rise;
    logic [PW-1:0] pre;
    logic        tick;
    logic [15:0] timer, timer_inc;
    logic [15:0] width, w_base, w_new;
    logic        over, accept, short_nx, clamp_nx, trans;
    logic        echo_q, busy_q, short_q, clamp_q;

    // Two-flop synchronizer plus one delay flop for edge detection
    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            trig_s1 <= 1'b0;
            trig_s2 <= 1'b0;
            trig_d  <= 1'b0;
        end else begin
            trig_s1 <= bus.trig;
            trig_s2 <= trig_s1;
            trig_d  <= trig_s2;
        end
    end

    assign rise      = trig_s2 & ~trig_d;
    assign tick      = (pre == PW'(DIV - 1));
    assign timer_inc = timer + 16'd1;

    assign over   = (bus.distance_us > MAX_T);
    assign w_base = over ? MAX_T : ((bus.distance_us == 16'd0) ? 16'd1 : bus.distance_us);

`ifdef ECHO_JITTER_EN
    logic [7:0] lfsr;

    // Jitter uses the current LFSR value, then the LFSR steps for the next trigger
    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset)
            lfsr <= 8'hA5;
        else if (accept)
            lfsr <= {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
    end

    assign w_new = w_base + {13'd0, lfsr[2:0]};
`else
    assign w_new = w_base;
`endif

    always_comb begin
        state_nx = state;
        accept   = 1'b0;
        short_nx = 1'b0;
        clamp_nx = 1'b0;
        unique case (state)
            S_IDLE: begin
                if (rise)
                    state_nx = S_TRIG_HI;
            end
            S_TRIG_HI: begin
                if (!trig_s2) begin
                    if (timer < MIN_T) begin
                        short_nx = 1'b1;
                        state_nx = S_IDLE;
                    end else begin
                        accept   = 1'b1;
                        clamp_nx = over;
                        state_nx = S_BURST;
                    end
                end
            end
            S_BURST: begin
                if (tick && timer_inc == BURST_T)
                    state_nx = S_ECHO;
            end
            S_ECHO: begin
                if (tick && timer_inc == width)
                    state_nx = S_HOLDOFF;
            end
            S_HOLDOFF: begin
                if (tick && timer_inc == HOLD_T)
                    state_nx = S_IDLE;
            end
            default: state_nx = S_IDLE;
        endcase
    end

    assign trans = (state_nx != state);

    // Timebase restarts on every transition so each phase is an exact multiple of DIV
    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            state <= S_IDLE;
            pre   <= '0;
            timer <= '0;
            width <= 16'd1;
        end else begin
            state <= state_nx;
            if (trans || tick)
                pre <= '0;
            else
                pre <= pre + PW'(1);
            if (trans)
                timer <= '0;
            else if (tick && timer != 16'hFFFF)
                timer <= timer_inc;
            if (accept)
                width <= w_new;
        end
    end

    // Outputs are registered from next-state so echo rises on the BURST->ECHO edge
    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            echo_q  <= 1'b0;
            busy_q  <= 1'b0;
            short_q <= 1'b0;
            clamp_q <= 1'b0;
        end else begin
            echo_q  <= (state_nx == S_ECHO);
            busy_q  <= (state_nx == S_BURST) || (state_nx == S_ECHO) || (state_nx == S_HOLDOFF);
            short_q <= short_nx;
            clamp_q <= clamp_nx;
        end
    end

    assign bus.echo       = echo_q;
    assign bus.busy       = busy_q;
    assign bus.trig_short = short_q;
    assign bus.clamped    = clamp_q;

endmodule

// File: tb/tb_ultrasonic_echo_responder.sv
// Scoreboard bench for ultrasonic_echo_responder: randomized triggers checked against a
// queue-based reference model (honours ECHO_JITTER_EN when defined).
module tb_ultrasonic_echo_responder;

    localparam int CLK_HZ = 4000000;
    localparam int DIV    = CLK_HZ / 1000000;
    localparam int MIN_US = 10;
    localparam int BUR_US = 20;
    localparam int MAX_US = 300;
    localparam int HOL_US = 50;
    localparam int LIMIT  = (BUR_US + MAX_US + 8 + HOL_US + 40) * DIV;

    typedef struct {
        longint fall;
        int     wclk;
        bit     clamp;
    } exp_t;

    logic   clk = 1'b0;
    logic   nreset = 1'b0;
    longint cyc = 0;
    int     total = 0;
    int     bad = 0;
    exp_t   exp_q[$];
    int     short_pending = 0;
    bit     clamp_seen = 0;
    int     lfsr_m = 8'hA5;

    ultrasonic_echo_responder_if bus();

    ultrasonic_echo_responder #(
        .CLK_HZ(CLK_HZ), .MIN_TRIG_US(MIN_US), .BURST_US(BUR_US),
        .MAX_ECHO_US(MAX_US), .HOLDOFF_US(HOL_US)
    ) dut (
        .clk(clk),
        .nreset(nreset),
        .bus(bus)
    );

    always #5 clk = ~clk;

    initial forever begin
        @(posedge clk);
        cyc = cyc + 1;
    end

    initial begin
        #900000;
        $display("FAIL global_timeout: got cyc=%0d required finish", cyc);
        $fatal(1, "timeout");
    end

    task automatic chk(input string nm, input bit ok, input longint act, input longint exp);
        total++;
        if (!ok) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    // Reference width in microseconds from the sensor rules
    task automatic model_width(input int d, output int w, output bit cl);
        cl = (d > MAX_US);
        w  = cl ? MAX_US : ((d == 0) ? 1 : d);
`ifdef ECHO_JITTER_EN
        w = w + (lfsr_m % 8);
        lfsr_m = ((lfsr_m << 1) | (((lfsr_m >> 7) ^ (lfsr_m >> 5) ^ (lfsr_m >> 4) ^ (lfsr_m >> 3)) & 1)) & 255;
`endif
    endtask

    // mode: 0 = short (expect trig_short), 1 = accepted, 2 = ignored (busy)
    task automatic fire(input int d, input int hi_us, input int mode);
        exp_t e;
        int   w;
        bit   cl;
        bus.distance_us = 16'(d);
        @(posedge clk); #1 bus.trig = 1'b1;
        repeat (hi_us * DIV) @(posedge clk);
        #1 bus.trig = 1'b0;
        if (mode == 1) begin
            model_width(d, w, cl);
            e.fall  = cyc;
            e.wclk  = w * DIV;
            e.clamp = cl;
            exp_q.push_back(e);
        end else if (mode == 0) begin
            short_pending++;
        end
        repeat (6) @(posedge clk);
        #1 bus.distance_us = 16'($urandom);
    endtask

    task automatic wait_idle();
        int n = 0;
        repeat (6) @(posedge clk);
        while ((bus.busy || bus.echo) && n < LIMIT) begin
            @(posedge clk);
            n++;
        end
        if (n >= LIMIT) chk("idle_timeout", 0, n, LIMIT);
        repeat (4) @(posedge clk);
    endtask

    task automatic wait_echo(input logic v);
        int n = 0;
        while (bus.echo !== v && n < LIMIT) begin
            @(posedge clk); #1;
            n++;
        end
        if (n >= LIMIT) chk("echo_wait_timeout", 0, n, LIMIT);
    endtask

    // Monitor: pops expectations when the DUT presents echo / flag events
    initial begin
        bit     pe = 0, pb = 0, ps = 0, pc = 0;
        longint rise_c = 0, efall_c = 0;
        exp_t   e;
        forever begin
            @(negedge clk);
            if (!nreset) begin
                pe = 0; pb = 0; ps = 0; pc = 0;
            end else begin
                if (bus.echo && !pe) begin
                    rise_c = cyc;
                    if (exp_q.size() == 0) chk("echo_unexpected", 0, 1, 0);
                    else chk("echo_delay", (cyc - exp_q[0].fall) >= BUR_US * DIV &&
                             (cyc - exp_q[0].fall) <= BUR_US * DIV + 3,
                             cyc - exp_q[0].fall, BUR_US * DIV);
                end
                if (!bus.echo && pe) begin
                    efall_c = cyc;
                    if (exp_q.size() == 0) chk("echo_fall_unexpected", 0, 1, 0);
                    else begin
                        e = exp_q.pop_front();
                        chk("echo_width", (cyc - rise_c) == e.wclk, cyc - rise_c, e.wclk);
                        chk("clamp_flag", clamp_seen == e.clamp, clamp_seen, e.clamp);
                        clamp_seen = 0;
                    end
                end
                if (bus.busy && !pb) begin
                    if (exp_q.size() == 0) chk("busy_unexpected", 0, 1, 0);
                    else chk("busy_rise", (cyc - exp_q[0].fall) >= 1 && (cyc - exp_q[0].fall) <= 3,
                             cyc - exp_q[0].fall, 3);
                end
                if (!bus.busy && pb)
                    chk("busy_fall", (cyc - efall_c) == HOL_US * DIV, cyc - efall_c, HOL_US * DIV);
                if (bus.trig_short) begin
                    chk("short_pulse", !ps && short_pending > 0, short_pending, 1);
                    if (short_pending > 0 && !ps) short_pending--;
                end
                if (bus.clamped) begin
                    chk("clamp_pulse", !pc && exp_q.size() > 0 && bus.busy && exp_q.size() > 0 && exp_q[0].clamp,
                        pc, 0);
                    clamp_seen = 1;
                end
                pe = bus.echo; pb = bus.busy; ps = bus.trig_short; pc = bus.clamped;
            end
        end
    end

    initial begin
        bus.trig = 1'b0;
        bus.distance_us = 16'd0;
        repeat (4) @(posedge clk);
        #1;
        chk("rst_echo", bus.echo == 1'b0, bus.echo, 0);
        chk("rst_busy", bus.busy == 1'b0, bus.busy, 0);
        chk("rst_short", bus.trig_short == 1'b0, bus.trig_short, 0);
        chk("rst_clamped", bus.clamped == 1'b0, bus.clamped, 0);
        nreset = 1'b1;
        repeat (3) @(posedge clk);

        fire(100, 12, 1);  wait_idle();
        fire(100, 9, 0);   wait_idle();
        fire(5000, 12, 1); wait_idle();
        fire(0, 12, 1);    wait_idle();
        fire(MAX_US, 12, 1); wait_idle();
        fire(MAX_US + 1, 15, 1); wait_idle();

        // Trigger inside holdoff is ignored; one just after holdoff is accepted
        fire(20, 12, 1);
        wait_echo(1'b1);
        wait_echo(1'b0);
        repeat (10 * DIV) @(posedge clk);
        fire(77, 12, 2);
        wait_idle();
        repeat (DIV) @(posedge clk);
        fire(40, 12, 1);   wait_idle();

        for (int i = 0; i < 15; i++) begin
            int d  = $urandom_range(0, 400);
            bit ok = $urandom_range(0, 2) != 0;
            if (ok) fire(d, $urandom_range(11, 20), 1);
            else    fire(d, $urandom_range(2, 8), 0);
            wait_idle();
        end

        // Reset in the middle of an echo drops it immediately
        fire(200, 12, 1);
        wait_echo(1'b1);
        repeat (20) @(posedge clk);
        #3 nreset = 1'b0;
        #1;
        chk("rst_mid_echo", bus.echo == 1'b0, bus.echo, 0);
        chk("rst_mid_busy", bus.busy == 1'b0, bus.busy, 0);
        exp_q.delete();
        clamp_seen = 0;
        short_pending = 0;
        lfsr_m = 8'hA5;
        repeat (3) @(posedge clk);
        #1 nreset = 1'b1;
        repeat (2) @(posedge clk);
        fire(300, 12, 1);  wait_idle();

        chk("scoreboard_drained", exp_q.size() == 0 && short_pending == 0,
            exp_q.size() + short_pending, 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
